// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and sizing constants for the BRAM port arbiter
//
// Purpose: FSM state type and default geometry of the shared 256x32 RAM macro.
// Ports: none (package).
package bram_arb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with priority flop
//
// Purpose: combinational grant between two requesters; priority passes to the
//          loser after every grant.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (priority -> requester 0)
//   en         - arbitration enable; no grant is issued while low
//   valid[1:0] - request valid per requester
//   grant[1:0] - one-hot grant (or zero when idle / disabled)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  // prio_q = 0: requester 0 wins a tie; 1: requester 1 wins a tie
  logic prio_q;
  logic prio_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end

    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - two-requester arbiter in front of a 1rw1r byte-maskable RAM macro
//
// Purpose: after reset, sweeps every RAM word to INIT_VALUE, then grants at most
//          one access per cycle to two valid/ready requesters (round-robin).
//          Writes go to RAM port 0, reads to port 1; read data returns on a
//          shared bus qualified by a per-requester rsp_valid pulse.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   req_valid/req_ready         - per-requester handshake (bit i = requester i)
//   req_we/addr/wmask/wdata     - per-requester payload, requester i in slice i
//   rsp_valid/rsp_rdata         - read response (no backpressure)
//   init_done                   - high once the init sweep has finished
//   ram_csb0/web0/wmask0/addr0/din0 - RAM write port (active-low enables)
//   ram_csb1/addr1/dout1        - RAM read port, dout1 valid one cycle after capture
// Config: define BRAM_ARB_RSP_REG_EN to add an output register on the read
//         response (read latency 2 instead of 1).
module bram_port_arbiter #(
  parameter int                         ADDR_W     = bram_arb_pkg::ADDR_W,
  parameter int                         DATA_W     = bram_arb_pkg::DATA_W,
  parameter logic [DATA_W-1:0]          INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_W-1:0]     req_addr,
  input  logic [2*(DATA_W/8)-1:0] req_wmask,
  input  logic [2*DATA_W-1:0]     req_wdata,
  output logic [1:0]              rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    init_done,
  output logic                    ram_csb0,
  output logic                    ram_web0,
  output logic [DATA_W/8-1:0]     ram_wmask0,
  output logic [ADDR_W-1:0]       ram_addr0,
  output logic [DATA_W-1:0]       ram_din0,
  output logic                    ram_csb1,
  output logic [ADDR_W-1:0]       ram_addr1,
  input  logic [DATA_W-1:0]       ram_dout1
);

  import bram_arb_pkg::*;

  localparam int WMASK_W = DATA_W / 8;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          rsp_valid_q, rsp_valid_d;
  logic [1:0]          grant;
  logic                sel;
  logic                arb_en;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WMASK_W-1:0]  sel_wmask;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_we;
  logic [DATA_W-1:0]   stage_rdata;

  // Requests are only considered in RUN, and never while reset is held, so a
  // reset cycle presents the idle/reset values on every output.
  assign arb_en = (state_q == RUN) && !rst;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .valid (req_valid),
    .grant (grant)
  );

  assign req_ready = grant;
  assign init_done = (state_q == RUN) && !rst;

  // Payload of the granted requester (grant is one-hot, so bit 1 selects)
  assign sel       = grant[1];
  assign sel_we    = sel ? req_we[1] : req_we[0];
  assign sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign sel_wmask = sel ? req_wmask[2*WMASK_W-1:WMASK_W] : req_wmask[WMASK_W-1:0];
  assign sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = RUN;
      end
    end
  end

  // RAM pin drive: init sweep, granted write, granted read, or idle
  always_comb begin
    ram_csb0   = 1'b1;
    ram_web0   = 1'b1;
    ram_wmask0 = '0;
    ram_addr0  = '0;
    ram_din0   = '0;
    ram_csb1   = 1'b1;
    ram_addr1  = '0;
    if (!rst) begin
      if (state_q == INIT) begin
        ram_csb0   = 1'b0;
        ram_web0   = 1'b0;
        ram_wmask0 = '1;
        ram_addr0  = cnt_q;
        ram_din0   = INIT_VALUE;
      end else if (grant != 2'b00) begin
        if (sel_we) begin
          ram_csb0   = 1'b0;
          ram_web0   = 1'b0;
          ram_wmask0 = sel_wmask;
          ram_addr0  = sel_addr;
          ram_din0   = sel_wdata;
        end else begin
          ram_csb1  = 1'b0;
          ram_addr1 = sel_addr;
        end
      end
    end
  end

  // A read grant this cycle becomes a response when ram_dout1 is valid next cycle
  assign rsp_valid_d = grant & ~req_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign stage_rdata = (rsp_valid_q != 2'b00) ? ram_dout1 : '0;

`ifdef BRAM_ARB_RSP_REG_EN
  logic [1:0]        out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_rdata_q, out_rdata_d;

  assign out_valid_d = rsp_valid_q;
  assign out_rdata_d = stage_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 2'b00;
      out_rdata_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
    end
  end

  assign rsp_valid = out_valid_q & {2{!rst}};
  assign rsp_rdata = rst ? '0 : out_rdata_q;
`else
  // Gating with rst drops a response that would land in a reset cycle
  assign rsp_valid = rsp_valid_q & {2{!rst}};
  assign rsp_rdata = rst ? '0 : stage_rdata;
`endif

endmodule
